// File: rtl/multi_ratio_divider.sv
// multi_ratio_divider: N-channel rational rate generator (outclk = inclk * mult/div).
// Double-buffered ratios, per-channel enable, fixed-width pulses with one-deep pending.
module multi_ratio_divider #(
    parameter int CHANNELS     = 4,
    parameter int COUNT_BITS   = 32,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           inclk,
    input  logic [CHANNELS-1:0]            enable,
    input  logic                           load,
    input  logic                           clear_flags,
    input  logic [CHANNELS*COUNT_BITS-1:0] multiplicand,
    input  logic [CHANNELS*COUNT_BITS-1:0] dividend,
    output logic [CHANNELS-1:0]            outclk,
    output logic [CHANNELS-1:0]            ratio_err,
    output logic [CHANNELS-1:0]            overrun
);
    localparam int CB = COUNT_BITS;
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_INIT = PW'(PULSE_CYCLES);

    logic r_s1, r_s2, r_s3;
    logic w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= inclk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_tick = r_s2 & ~r_s3;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic [CB-1:0] r_mult, r_div, r_acc;
            logic [PW-1:0] r_pcnt;
            logic          r_pend, r_out, r_err, r_ovr;
            logic [CB:0]   w_sum, w_diff;
            logic          w_zero, w_sat, w_go, w_trig, w_busy;

            assign w_zero = (r_div == '0);
            assign w_sat  = (r_mult > r_div);
            assign w_sum  = {1'b0, r_acc} + {1'b0, r_mult};
            assign w_diff = w_sum - {1'b0, r_div};
            assign w_go   = w_tick & enable[i] & ~load & ~w_zero;
            // Oversized ratios saturate to one trigger per tick.
            assign w_trig = w_go & (w_sat | (w_sum >= {1'b0, r_div}));
            assign w_busy = (r_pcnt != '0) | r_pend;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mult <= '0;
                    r_div  <= '0;
                    r_acc  <= '0;
                    r_pcnt <= '0;
                    r_pend <= 1'b0;
                    r_out  <= 1'b0;
                    r_err  <= 1'b0;
                    r_ovr  <= 1'b0;
                end else begin
                    r_err <= w_zero | w_sat;
                    if (load) begin
                        r_mult <= multiplicand[i*CB +: CB];
                        r_div  <= dividend[i*CB +: CB];
                        r_acc  <= '0;
                    end else if (w_go) begin
                        if (w_sat)
                            r_acc <= '0;
                        else if (w_trig)
                            r_acc <= w_diff[CB-1:0];
                        else
                            r_acc <= w_sum[CB-1:0];
                    end
                    // The cycle with pcnt==0 after a pulse is the forced low gap.
                    if (r_pcnt != '0) begin
                        r_pcnt <= r_pcnt - 1'b1;
                        if (r_pcnt == PW'(1))
                            r_out <= 1'b0;
                    end else if (r_pend) begin
                        r_pcnt <= PULSE_INIT;
                        r_out  <= 1'b1;
                        r_pend <= 1'b0;
                    end else if (w_trig) begin
                        r_pcnt <= PULSE_INIT;
                        r_out  <= 1'b1;
                    end
                    if (w_trig && w_busy && !r_pend)
                        r_pend <= 1'b1;
                    if (w_trig && r_pend)
                        r_ovr <= 1'b1;
                    else if (clear_flags)
                        r_ovr <= 1'b0;
                end
            end

            assign outclk[i]    = r_out;
            assign ratio_err[i] = r_err;
            assign overrun[i]   = r_ovr;
        end
    endgenerate
endmodule
